// File: rtl/mux_selftest_sequencer.sv
// Self-test sequencer for a 2:1 select stage y = b ? s0 : s1.
// Walks {s1,s0,b} through all 8 vectors, samples y_in and tallies mismatches.
module mux_selftest_sequencer #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       y_in,
  output logic       s0,
  output logic       s1,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_fail
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES);

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [3:0]       err_q, err_d;
  logic [2:0]       ff_q, ff_d;
  logic             expected;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

  // idx maps to {s1,s0,b}, so the golden value is b ? s0 : s1
  assign expected = idx_q[0] ? idx_q[1] : idx_q[2];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    ff_d    = ff_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (abort) begin
          pass_d = 1'b0;
        end else if (start) begin
          state_d = ST_DRIVE;
          idx_d   = '0;
          vec_d   = '0;
          cnt_d   = HOLD_LD;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = '0;
          ff_d    = '0;
        end
      end

      ST_DRIVE: begin
        // abort discards any sample that coincides with it
        if (abort) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          vec_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (cnt_q == CNT_W'(1)) begin
          if (y_in != expected) begin
            err_d = err_q + 4'd1;
            if (err_q == 4'd0) begin
              ff_d = idx_q;
            end
          end
          if (idx_q == 3'd7) begin
            state_d = ST_DONE;
            idx_d   = '0;
            vec_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == 4'd0);
          end else begin
            idx_d = idx_q + 3'd1;
            vec_d = idx_q + 3'd1;
            cnt_d = HOLD_LD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign {s1, s0, b}  = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_count    = err_q;
  assign first_fail   = ff_q;

endmodule

// File: tb/tb_mux_selftest_sequencer.sv
// Directed bench for mux_selftest_sequencer: HOLD_CYCLES=4 and HOLD_CYCLES=1 instances
// driven by behavioural select-stage models with hand-computed expectations.
module tb_mux_selftest_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start, abort;
  logic       y4, s04, s14, b4, busy4, done4, pass4;
  logic [3:0] err4;
  logic [2:0] ff4;
  logic       start1, abort1;
  logic       y1, s01, s11, b1, busy1, done1, pass1;
  logic [3:0] err1;
  logic [2:0] ff1;
  int         ymode;
  int         checks;
  int         errors;

  mux_selftest_sequencer #(.HOLD_CYCLES(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .y_in(y4),
    .s0(s04), .s1(s14), .b(b4), .busy(busy4), .done(done4), .pass(pass4),
    .err_count(err4), .first_fail(ff4)
  );

  mux_selftest_sequencer #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .y_in(y1),
    .s0(s01), .s1(s11), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail(ff1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Select-stage models: 0 golden, 1 stuck-at-0, 2 inverted, 3 swapped
  always_comb begin
    case (ymode)
      0:       y4 = b4 ? s04 : s14;
      1:       y4 = 1'b0;
      2:       y4 = ~(b4 ? s04 : s14);
      3:       y4 = b4 ? s14 : s04;
      default: y4 = 1'b0;
    endcase
  end

  assign y1 = b1 ? s01 : s11;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full HOLD_CYCLES=4 run; extraAt>0 re-asserts start at edge E0+extraAt
  task automatic applyStimulus(input int mode, input int extraAt, input logic [3:0] expErr,
                               input logic [2:0] expFf, input logic expPass, input string tag);
    logic [2:0] vi;
    @(negedge clk);
    ymode = mode;
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 33; k++) begin
      @(negedge clk);
      start = (extraAt == k + 1);
      vi = 3'(k / 4);
      if (k < 32) begin
        checkOutput({tag, "_vec"}, {3'b0, done4, busy4, s14, s04, b4}, {4'b0001, vi});
      end else if (k == 32) begin
        checkOutput({tag, "_done"}, {6'b0, done4, busy4}, 8'h02);
        checkOutput({tag, "_idle_vec"}, {5'b0, s14, s04, b4}, 8'h00);
        checkOutput({tag, "_err"}, {4'b0, err4}, {4'b0, expErr});
        checkOutput({tag, "_ff"}, {5'b0, ff4}, {5'b0, expFf});
        checkOutput({tag, "_pass"}, {7'b0, pass4}, {7'b0, expPass});
      end else begin
        checkOutput({tag, "_done_pulse_end"}, {6'b0, done4, pass4}, {7'b0, expPass});
      end
    end
  endtask

  initial begin
    logic sawDone;
    checks = 0;
    errors = 0;
    ymode  = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    start1 = 1'b0;
    abort1 = 1'b0;
    #7;
    checkOutput("reset_outs", {busy4, done4, pass4, s14, s04, b4, 2'b0}, 8'h00);
    checkOutput("reset_err_ff", {1'b0, err4, ff4}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_after_reset", {busy4, done4, pass4, 5'b0}, 8'h00);

    $display("[TB] golden run with ignored start at E0+5");
    applyStimulus(0, 5, 4'd0, 3'd0, 1'b1, "golden");

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_in_done_pass", {6'b0, pass4, busy4}, 8'h00);

    $display("[TB] stuck-at-0 run");
    applyStimulus(1, 0, 4'd4, 3'd3, 1'b0, "stuck0");
    $display("[TB] inverted run");
    applyStimulus(2, 0, 4'd8, 3'd0, 1'b0, "inverted");
    $display("[TB] swapped run");
    applyStimulus(3, 0, 4'd4, 3'd2, 1'b0, "swapped");

    $display("[TB] golden run aborted at E0+10");
    @(negedge clk);
    ymode = 0;
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
      abort = (k == 9);
    end
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_outs", {busy4, done4, pass4, s14, s04, b4, 2'b0}, 8'h00);
    checkOutput("abort_err", {4'b0, err4}, 8'h00);
    sawDone = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      sawDone = sawDone | done4 | busy4;
    end
    checkOutput("abort_no_done", {7'b0, sawDone}, 8'h00);

    $display("[TB] asynchronous reset mid-run");
    @(negedge clk);
    ymode = 2;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("pre_reset_err", {4'b0, err4}, 8'h03);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset_outs", {busy4, done4, pass4, s14, s04, b4, 2'b0}, 8'h00);
    checkOutput("midrun_reset_err_ff", {1'b0, err4, ff4}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    ymode = 0;
    sawDone = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      sawDone = sawDone | done4 | busy4;
    end
    checkOutput("reset_no_done", {7'b0, sawDone}, 8'h00);

    $display("[TB] HOLD_CYCLES=1 golden run");
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (k < 8) begin
        checkOutput("h1_vec", {3'b0, done1, busy1, s11, s01, b1}, {5'b00001, 3'(k)});
      end else begin
        checkOutput("h1_done", {5'b0, done1, busy1, pass1}, 8'h05);
        checkOutput("h1_err", {4'b0, err1}, 8'h00);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_selftest_sequencer.md
Name: mux_selftest_sequencer

Overview:
- Upstream driver and checker for the 2:1 select stage y = (s0 & b) | (s1 & ~b).
- Select semantics: b=1 passes s0, b=0 passes s1.
- On start, steps {s1,s0,b} through all 8 combinations, holds each for HOLD_CYCLES clocks, samples the returned y and compares it against the expected value.
- Reports mismatch count, first failing vector index, and a pass flag; sits between the lab board controls and the combinational stage.

Parameters:
- HOLD_CYCLES, 4, clocks each vector is held before y_in is sampled (legal range 1..255).
- CNT_W, 8, width of the internal hold counter; must hold HOLD_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  synchronous run request; honoured in IDLE or DONE only.
- abort  input  1  synchronous run cancel.
- y_in  input  1  y returned from the select stage.
- s0  output  1  data input 0 to the select stage (registered).
- s1  output  1  data input 1 to the select stage (registered).
- b  output  1  select to the select stage (registered).
- busy  output  1  high while vectors are being driven.
- done  output  1  one-cycle pulse at run completion.
- pass  output  1  high when the last completed run had zero mismatches; held until the next start.
- err_count  output  4  mismatches in the current or last run, 0..8.
- first_fail  output  3  index of the first mismatching vector; meaningful only when err_count != 0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State = IDLE.
  - s0=s1=b=0, busy=0, done=0, pass=0, err_count=0, first_fail=0.
  - Vector index = 0, hold counter = 0.
- States: IDLE, DRIVE, DONE.
- Vector mapping: idx[2:0] = {s1,s0,b}. Expected value = b ? s0 : s1.
- IDLE/DONE + start=1 at edge E0:
  - Enter DRIVE; idx=0 is driven from E0.
  - busy=1; err_count=0; first_fail=0; pass=0.
  - Hold counter loaded with HOLD_CYCLES.
- DRIVE:
  - Hold counter decrements each edge.
  - At the edge where the counter equals 1: compare y_in with the expected value for the current idx.
  - On mismatch: err_count increments; if err_count was 0, first_fail = idx.
  - Vector idx+1 is driven from that same edge and the counter reloads.
  - Sample edges for idx k are at E0 + (k+1)*HOLD_CYCLES.
- After idx 7 is sampled (edge E0 + 8*HOLD_CYCLES):
  - Enter DONE; done=1 for exactly that one cycle.
  - busy=0; s0=s1=b=0.
  - pass = (final err_count == 0), including the idx-7 result.
- DONE: remains until start; err_count, first_fail and pass hold their values.
- start while busy: ignored, no effect on the run.
- abort:
  - Wins over start and over a coincident sample edge; that sample is discarded.
  - From DRIVE: go to IDLE, s0=s1=b=0, busy=0, no done pulse, pass=0; err_count and first_fail keep their partial values.
  - In IDLE/DONE: clears pass only.
- Reset mid-run: immediate return to reset values; no done pulse.
- err_count cannot exceed 8; no saturation logic beyond width is needed.
- HOLD_CYCLES=1: a new vector every clock; sampling is one cycle after drive.

Test Plan:
- Golden mux model, HOLD_CYCLES=4, start pulse at E0 -> done at E0+32; err_count=0, pass=1, busy high for 32 cycles; b/s0/s1 sequence 000..111.
- y_in stuck at 0 -> mismatches at idx 3,4,6,7; err_count=4, first_fail=3, pass=0.
- y_in = inverted mux -> err_count=8, first_fail=0, pass=0.
- Swapped mux model (y = b ? s1 : s0) -> mismatches at idx 2,3,4,5; err_count=4, first_fail=2.
- abort asserted at E0+10 with golden model -> IDLE next edge, no done, pass=0, err_count=0; start asserted at E0+5 during the run -> ignored, done still at E0+32.
- rst_n low at E0+13 (asynchronous, mid-cycle) -> all outputs 0 immediately; HOLD_CYCLES=1 golden run -> done at E0+8, pass=1.
